uart_rx_os: RTL
===============

# uart_rx_os

Parametrised oversampling UART receiver: successor to the fixed 115200-baud receiver fed by an external 16× clock divider. Generates its own oversample tick from the system clock, synchronises and majority-votes the serial line, and reports received words with framing (and optionally parity) error flags. Sits between a board pin and command-decode logic in the top level, all in a single clock domain.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 115_200, line bit rate
- OVERSAMPLE, 16, ticks per bit; even, ≥ 8
- DATA_BITS, 8, word width, 5..9
- PARITY_ODD, 0, parity sense when parity compiled in: 0 = even, 1 = odd
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  raw serial line, idle high, asynchronous to clk
- out  output  DATA_BITS  last received word, LSB first on the line
- valid  output  1  one-cycle pulse: out holds a good word
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without macro)
- busy  output  1  high while state ≠ IDLE

## Operation
- Divider DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), rounded; DIV ≥ 2 is checked at elaboration. Counter counts 0..DIV-1; tick is a one-cycle strobe at DIV-1; counter free-runs and is never resynchronised.
- rx passes a 2-flop synchroniser (reset value 1); all logic uses the synchronised value rxs.
- Per-bit counter os_cnt, 0..OVERSAMPLE-1, advances on tick only.
- Bit value = majority of rxs sampled at ticks os_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; decision at OVERSAMPLE/2+1.
- States:
  - IDLE: on rxs = 0 at a tick, os_cnt ← 0, go START.
  - START: at decision, majority 0 → DATA (bit index 0); majority 1 → IDLE (glitch, no flags).
  - DATA: shift majority into shift register LSB first; after bit DATA_BITS-1 → PARITY if compiled in, else STOP.
  - PARITY: compare majority with XOR of data (XNOR if PARITY_ODD); store mismatch; → STOP.
  - STOP: at decision, majority 1 → out ← shift register; valid pulses unless parity mismatch, in which case parity_err pulses instead; → IDLE. Majority 0 → out updated, frame_err pulses, no valid; → BREAK.
  - BREAK: wait for rxs = 1 at a tick, → IDLE.
- Returning to IDLE at stop mid-bit permits back-to-back frames with one stop bit.
- Flags mutually exclusive; at most one pulse per frame.

## Timing
- Reset: out = 0, valid = frame_err = parity_err = busy = 0, state IDLE, counters 0, synchroniser = 1. Reset mid-frame abandons it; no flags.
- Flags and out are registered: assert in the clk cycle after the stop-bit decision tick; out stable until next stop decision.
- Latency, start falling edge to valid: 2 clk (synchroniser) + ≤ 1 tick detection + (1 + DATA_BITS + P) bit periods + (OVERSAMPLE/2+1) ticks + 1 clk, P = 1 with parity else 0.
- Tolerated baud mismatch ≈ ±(OVERSAMPLE/2-1)/(OVERSAMPLE*(DATA_BITS+P+1.5)) relative.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present, parity_err driven, frame length +1 bit.
- Undefined: no PARITY state, parity_err tied 0, PARITY_ODD ignored.

## Structure
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK), divider rounding function, majority-of-3 function.
- Sub-module uart_baud_tick (parameters CLK_HZ, BAUD, OVERSAMPLE; ports clk, rst, tick) holds the divider, reusable by a future transmitter.

## Test plan
Defaults (DIV = 27, bit = 432 clk).
- Frame 0x30, stop high → out = 0x30, valid one cycle, no error flags, busy falls.
- Back-to-back 0x31 then 0x55, one stop bit, no idle gap → two valid pulses, out = 0x31 then 0x55.
- 120-clk low glitch on idle line, then frame 0xA5 → no flags from glitch; 0xA5 received with valid.
- 0x00 followed by stop held low 3 bit periods → frame_err one cycle, no valid, busy high until rx returns high; next 0x7E received.
- 50-clk inverted pulse centred on each data bit of 0x3C → majority vote still yields out = 0x3C, valid.
- rst asserted mid-byte (bit 4) → outputs 0 immediately; later 0x42 received cleanly. With UART_RX_PARITY_EN, even parity, 0x01 sent with parity bit 0 → parity_err, no valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver (and a future transmitter).
// Contents:
//   uart_state_e - receiver FSM states
//   calc_div     - rounded system-clock divider that produces the oversample tick
//   maj3         - majority of three samples
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // Rounded CLK_HZ / (BAUD * OVERSAMPLE).
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator.
// Parameters: CLK_HZ, BAUD, OVERSAMPLE (tick rate = BAUD * OVERSAMPLE).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   tick - one-cycle strobe while the divider counter sits at DIV-1
// The counter is never resynchronised to the serial line.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_tick: divider must be at least 2");
  end

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with on-chip baud tick, 2-flop input synchroniser
// and 3-sample majority vote per bit.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits).
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   rx         - raw serial line, idle high, asynchronous to clk
//   out        - last received word (LSB first on the line), held until next stop decision
//   valid      - one-cycle pulse: out holds a good word
//   frame_err  - one-cycle pulse: stop bit sampled low
//   parity_err - one-cycle pulse: parity mismatch (tied 0 without the macro)
//   busy       - high while the receiver is not idle
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_ONE   = OSW'(1);
  localparam logic [OSW-1:0] OS_A     = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_B     = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] OS_DEC   = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  BIT_ONE  = BW'(1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_chk
    $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_db_chk
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_par_chk
    $error("uart_rx_os: PARITY_ODD must be 0 or 1");
  end

  logic                 w_tick;
  logic                 w_rxs;
  logic                 w_maj;
  logic                 w_decide;
  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [OSW-1:0]       r_os_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic                 r_s_a;
  logic                 r_s_b;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_out;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_busy;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs    = r_sync2;
  // Third vote is the live sample taken on the decision tick itself.
  assign w_maj    = maj3(r_s_a, r_s_b, w_rxs);
  assign w_decide = w_tick && (r_os_cnt == OS_DEC);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_tick && !w_rxs) w_state_nxt = START;
        else                  w_state_nxt = r_state;
      end
      START: begin
        if (w_decide) w_state_nxt = w_maj ? IDLE : DATA;
        else          w_state_nxt = r_state;
      end
      DATA: begin
        if (w_decide && (r_bit_idx == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end else begin
          w_state_nxt = r_state;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_decide) w_state_nxt = STOP;
        else          w_state_nxt = r_state;
      end
`endif
      // Leaving STOP at mid-bit lets a following start edge be caught with one stop bit.
      STOP: begin
        if (w_decide) w_state_nxt = w_maj ? IDLE : BREAK;
        else          w_state_nxt = r_state;
      end
      BREAK: begin
        if (w_tick && w_rxs) w_state_nxt = IDLE;
        else                 w_state_nxt = r_state;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic r_parity_err;
  logic w_par_exp;
  assign w_par_exp = (PARITY_ODD != 0) ? ~(^r_shift) : (^r_shift);
`endif

  // Oversample counter, vote samples, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_os_cnt    <= {OSW{1'b0}};
      r_bit_idx   <= {BW{1'b0}};
      r_s_a       <= 1'b1;
      r_s_b       <= 1'b1;
      r_shift     <= {DATA_BITS{1'b0}};
      r_out       <= {DATA_BITS{1'b0}};
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= (w_state_nxt != IDLE);
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (w_tick) begin
        // The detecting tick counts as sample 0 of the start bit.
        if (r_state == IDLE) begin
          r_os_cnt <= w_rxs ? {OSW{1'b0}} : OS_ONE;
        end else if (r_os_cnt == OS_LAST) begin
          r_os_cnt <= {OSW{1'b0}};
        end else begin
          r_os_cnt <= r_os_cnt + OS_ONE;
        end
        if (r_os_cnt == OS_A) r_s_a <= w_rxs;
        if (r_os_cnt == OS_B) r_s_b <= w_rxs;
      end
      if (w_decide) begin
        case (r_state)
          START: begin
            r_bit_idx <= {BW{1'b0}};
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
          end
          DATA: begin
            r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + BIT_ONE;
          end
`ifdef UART_RX_PARITY_EN
          PARITY: r_par_err <= (w_maj != w_par_exp);
`endif
          STOP: begin
            r_out <= r_shift;
            if (w_maj) begin
`ifdef UART_RX_PARITY_EN
              if (r_par_err) r_parity_err <= 1'b1;
              else           r_valid      <= 1'b1;
`else
              r_valid <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out       = r_out;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
